// File: rtl/toom8_operand_loader_pkg.sv
// Shared constants and state encoding for the Toom-8 operand loader
// and the evaluation stage that consumes its chunks.
package toom8_pkg;

  localparam int WORD_W       = 64;
  localparam int OPERAND_W    = 1024;
  localparam int CHUNK_W      = 128;
  localparam int CHUNK_OUT_W  = CHUNK_W + 1;
  localparam int NUM_CHUNKS   = 8;
  localparam int WORDS_PER_OP = OPERAND_W / WORD_W;
  localparam int WCNT_W       = $clog2(WORDS_PER_OP);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_e;

endpackage

// File: rtl/toom8_operand_loader_if.sv
// Word-stream handshake into the operand loader.
// The master drives words; the slave returns ready.
interface toom8_operand_loader_if;
  import toom8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/toom8_operand_loader_word_packer.sv
// One operand register, written a word at a time by index.
// Cleared on reset, otherwise holds until overwritten.
module toom8_word_packer
  import toom8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [WCNT_W-1:0]    idx,
  input  logic [WORD_W-1:0]    wdata,
  output logic [OPERAND_W-1:0] q
);

  logic [OPERAND_W-1:0] data_q;
  logic [OPERAND_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d[int'(idx)*WORD_W +: WORD_W] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/toom8_operand_loader.sv
// Streams A then B into two operand registers and presents
// their 128-bit limbs, zero-extended, under a valid/ready pair.
module toom8_operand_loader
  import toom8_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  toom8_operand_loader_if.slave  in_if,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err,
  output logic [CHUNK_OUT_W-1:0] A_chunk0,
  output logic [CHUNK_OUT_W-1:0] A_chunk1,
  output logic [CHUNK_OUT_W-1:0] A_chunk2,
  output logic [CHUNK_OUT_W-1:0] A_chunk3,
  output logic [CHUNK_OUT_W-1:0] A_chunk4,
  output logic [CHUNK_OUT_W-1:0] A_chunk5,
  output logic [CHUNK_OUT_W-1:0] A_chunk6,
  output logic [CHUNK_OUT_W-1:0] A_chunk7,
  output logic [CHUNK_OUT_W-1:0] B_chunk0,
  output logic [CHUNK_OUT_W-1:0] B_chunk1,
  output logic [CHUNK_OUT_W-1:0] B_chunk2,
  output logic [CHUNK_OUT_W-1:0] B_chunk3,
  output logic [CHUNK_OUT_W-1:0] B_chunk4,
  output logic [CHUNK_OUT_W-1:0] B_chunk5,
  output logic [CHUNK_OUT_W-1:0] B_chunk6,
  output logic [CHUNK_OUT_W-1:0] B_chunk7
);

  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WORDS_PER_OP - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              we_a, we_b;
  logic [OPERAND_W-1:0] a_q, b_q;

  assign in_if.in_ready = (state_q != FULL) && !rst;
  assign xfer = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (xfer) begin
          we_a = 1'b1;
          if (in_if.in_last) begin
            err_d  = 1'b1;
            wcnt_d = '0;
          end else if (wcnt_q == WLAST) begin
            state_d = LOAD_B;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          we_b = 1'b1;
          // in_last must coincide exactly with B word 15
          if (in_if.in_last != (wcnt_q == WLAST)) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            wcnt_d  = '0;
          end else if (wcnt_q == WLAST) begin
            state_d = FULL;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign err       = err_q;

  toom8_word_packer u_pack_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we_a),
    .idx   (wcnt_q),
    .wdata (in_if.in_data),
    .q     (a_q)
  );

  toom8_word_packer u_pack_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we_b),
    .idx   (wcnt_q),
    .wdata (in_if.in_data),
    .q     (b_q)
  );

  assign A_chunk0 = {1'b0, a_q[0*CHUNK_W +: CHUNK_W]};
  assign A_chunk1 = {1'b0, a_q[1*CHUNK_W +: CHUNK_W]};
  assign A_chunk2 = {1'b0, a_q[2*CHUNK_W +: CHUNK_W]};
  assign A_chunk3 = {1'b0, a_q[3*CHUNK_W +: CHUNK_W]};
  assign A_chunk4 = {1'b0, a_q[4*CHUNK_W +: CHUNK_W]};
  assign A_chunk5 = {1'b0, a_q[5*CHUNK_W +: CHUNK_W]};
  assign A_chunk6 = {1'b0, a_q[6*CHUNK_W +: CHUNK_W]};
  assign A_chunk7 = {1'b0, a_q[7*CHUNK_W +: CHUNK_W]};
  assign B_chunk0 = {1'b0, b_q[0*CHUNK_W +: CHUNK_W]};
  assign B_chunk1 = {1'b0, b_q[1*CHUNK_W +: CHUNK_W]};
  assign B_chunk2 = {1'b0, b_q[2*CHUNK_W +: CHUNK_W]};
  assign B_chunk3 = {1'b0, b_q[3*CHUNK_W +: CHUNK_W]};
  assign B_chunk4 = {1'b0, b_q[4*CHUNK_W +: CHUNK_W]};
  assign B_chunk5 = {1'b0, b_q[5*CHUNK_W +: CHUNK_W]};
  assign B_chunk6 = {1'b0, b_q[6*CHUNK_W +: CHUNK_W]};
  assign B_chunk7 = {1'b0, b_q[7*CHUNK_W +: CHUNK_W]};

endmodule

// File: tb/tb_toom8_operand_loader.sv
// Scoreboard bench for the Toom-8 operand loader.
module tb_toom8_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_valid;
  logic out_ready = 1'b0;
  logic err;
  logic [128:0] ac [8];
  logic [128:0] bc [8];

  int n_chk = 0;
  int n_err = 0;
  int err_cnt = 0;

  logic [2047:0] sb [$];

  toom8_operand_loader_if bus ();

  toom8_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .A_chunk0  (ac[0]),
    .A_chunk1  (ac[1]),
    .A_chunk2  (ac[2]),
    .A_chunk3  (ac[3]),
    .A_chunk4  (ac[4]),
    .A_chunk5  (ac[5]),
    .A_chunk6  (ac[6]),
    .A_chunk7  (ac[7]),
    .B_chunk0  (bc[0]),
    .B_chunk1  (bc[1]),
    .B_chunk2  (bc[2]),
    .B_chunk3  (bc[3]),
    .B_chunk4  (bc[4]),
    .B_chunk5  (bc[5]),
    .B_chunk6  (bc[6]),
    .B_chunk7  (bc[7])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (out_valid) chk("ovalid_expected", 160'(sb.size() != 0), 160'(1));
  end

  task automatic send_word(input logic [63:0] d,
                           input bit l,
                           input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("in_ready_timeout", 160'(0), 160'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_pair(input logic [1023:0] a,
                           input logic [1023:0] b,
                           input bit gaps);
    for (int i = 0; i < 16; i++) send_word(a[64*i +: 64], 1'b0, gaps);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) sb.push_back({a, b});
      send_word(b[64*i +: 64], i == 15, gaps);
    end
    chk("ovalid_rise", 160'(out_valid), 160'(1));
  endtask

  task automatic consume(input int hold);
    int n;
    logic [2047:0] e;
    logic [1023:0] ea, eb;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) begin
      chk("ovalid_timeout", 160'(0), 160'(1));
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e  = sb[0];
    ea = e[2047:1024];
    eb = e[1023:0];
    repeat (hold) begin
      chk("hold_in_ready", 160'(bus.in_ready), 160'(0));
      chk("hold_A0", 160'(ac[0]), 160'({1'b0, ea[127:0]}));
      chk("hold_B7", 160'(bc[7]), 160'({1'b0, eb[1023:896]}));
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("A_chunk%0d", k), 160'(ac[k]),
          160'({1'b0, ea[128*k +: 128]}));
      chk($sformatf("B_chunk%0d", k), 160'(bc[k]),
          160'({1'b0, eb[128*k +: 128]}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    void'(sb.pop_front());
    chk("ovalid_fall", 160'(out_valid), 160'(0));
    chk("in_ready_after", 160'(bus.in_ready), 160'(1));
  endtask

  initial begin
    logic [1023:0] a, b;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", 160'(out_valid), 160'(0));
    chk("rst_err", 160'(err), 160'(0));
    chk("rst_in_ready", 160'(bus.in_ready), 160'(0));
    chk("rst_A0", 160'(ac[0]), 160'(0));
    chk("rst_B7", 160'(bc[7]), 160'(0));
    rst = 1'b0;
    #1;
    chk("in_ready_release", 160'(bus.in_ready), 160'(1));
    @(posedge clk);
    #1;

    // counting pattern with a 10-cycle hold in FULL
    for (int i = 0; i < 16; i++) begin
      a[64*i +: 64] = 64'(i + 1);
      b[64*i +: 64] = 64'(256 + i);
    end
    load_pair(a, b, 1'b0);
    @(negedge clk);
    chk("A_chunk0_k", 160'(ac[0]), 160'({1'b0, 64'h2, 64'h1}));
    chk("A_chunk7_k", 160'(ac[7]), 160'({1'b0, 64'h10, 64'hF}));
    chk("B_chunk3_k", 160'(bc[3]), 160'({1'b0, 64'h107, 64'h106}));
    consume(10);

    // all ones
    a = '1;
    b = '1;
    load_pair(a, b, 1'b0);
    consume(0);

    // in_last on A word 5
    for (int i = 0; i < 6; i++) send_word(64'(i + 7), i == 5, 1'b0);
    chk("err_a5", 160'(err), 160'(1));
    chk("err_a5_ovalid", 160'(out_valid), 160'(0));
    @(posedge clk);
    #1;
    chk("err_a5_width", 160'(err), 160'(0));
    chk("err_a5_ovalid2", 160'(out_valid), 160'(0));
    for (int i = 0; i < 16; i++) begin
      a[64*i +: 64] = {$urandom, $urandom};
      b[64*i +: 64] = {$urandom, $urandom};
    end
    load_pair(a, b, 1'b0);
    consume(0);

    // B word 15 without in_last
    for (int i = 0; i < 32; i++) send_word(64'(i * 3), 1'b0, 1'b0);
    chk("err_b15", 160'(err), 160'(1));
    chk("err_b15_ovalid", 160'(out_valid), 160'(0));
    @(posedge clk);
    #1;
    chk("err_b15_width", 160'(err), 160'(0));
    chk("err_b15_ready", 160'(bus.in_ready), 160'(1));
    chk("err_b15_ovalid2", 160'(out_valid), 160'(0));

    // random gaps, reset after B word 7, then full reload
    for (int i = 0; i < 16; i++) send_word({$urandom, $urandom}, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 160'(bus.in_ready), 160'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ovalid", 160'(out_valid), 160'(0));
    chk("mid_rst_A0", 160'(ac[0]), 160'(0));
    for (int i = 0; i < 16; i++) begin
      a[64*i +: 64] = {$urandom, $urandom};
      b[64*i +: 64] = {$urandom, $urandom};
    end
    load_pair(a, b, 1'b1);
    consume(0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_total", 160'(err_cnt), 160'(2));
    chk("sb_empty", 160'(sb.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
